// File: rtl/nabp_processing_data_path_if.sv
// Host-kick, filtered-RAM and PE-array signals of the NABP processing data path.
// The master side is the surrounding system; the slave side is the data path.
interface nabp_processing_data_path_if #(
  parameter int kNoOfPartitions     = 4,
  parameter int kFilteredDataLength = 16,
  parameter int kSLength            = 9,
  parameter int kSFracLength        = 8,
  parameter int kScanLenLength      = 9
);
  logic                                          tt_kick;
  logic [kSLength+kSFracLength:0]                tt_s_init;
  logic [kSLength+kSFracLength:0]                tt_s_step;
  logic [kScanLenLength-1:0]                     tt_scan_len;
  logic                                          tt_busy;
  logic                                          tt_done;
  logic [kSLength-1:0]                           pv_s_val;
  logic [kFilteredDataLength-1:0]                pv_val;
  logic                                          pe_hold;
  logic                                          pe_en;
  logic [kFilteredDataLength*kNoOfPartitions-1:0] pe_taps;

  modport master (
    output tt_kick, tt_s_init, tt_s_step, tt_scan_len, pv_val, pe_hold,
    input  tt_busy, tt_done, pv_s_val, pe_en, pe_taps
  );

  modport slave (
    input  tt_kick, tt_s_init, tt_s_step, tt_scan_len, pv_val, pe_hold,
    output tt_busy, tt_done, pv_s_val, pe_en, pe_taps
  );
endinterface

// File: rtl/nabp_processing_data_path.sv
// Walks a fixed-point s coordinate along one scan line, reads filtered samples
// from RAM and presents them to the PE array through a tapped delay chain.
module nabp_processing_data_path #(
  parameter int kNoOfPartitions     = 4,
  parameter int kTapDelay           = 2,
  parameter int kFilteredDataLength = 16,
  parameter int kSLength            = 9,
  parameter int kSFracLength        = 8,
  parameter int kProjLineSize       = 367,
  parameter int kScanLenLength      = 9
) (
  input logic                        clk,
  input logic                        reset_n,
  nabp_processing_data_path_if.slave bus
);
  localparam int W  = kFilteredDataLength;
  localparam int AW = kSLength + kSFracLength + 2;
  localparam int K  = (kNoOfPartitions - 1) * kTapDelay;
  localparam int CL = K + 1;
  localparam int CW = kScanLenLength + $clog2(K + 2) + 1;
  localparam logic signed [AW-1:0] LINE_END = AW'(kProjLineSize);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic signed [AW-1:0] acc, step_r, init_x, step_x, s_cur, s_floor;
  logic                 s_ok, kick_go, advance, last_cap;
  logic [kSLength-1:0]  addr_r;
  logic                 addr_ok, iss, adv_q;
  logic [W-1:0]         data_q;
  logic [W-1:0]         chain [CL];
  logic [CW-1:0]        total, iss_cnt, cap_cnt;
  logic                 busy_o, done_o, en_o;
  logic [W*kNoOfPartitions-1:0] taps;

  assign init_x   = {bus.tt_s_init[AW-2], bus.tt_s_init};
  assign step_x   = {bus.tt_s_step[AW-2], bus.tt_s_step};
  assign s_cur    = (state == IDLE) ? init_x : acc;
  assign s_floor  = s_cur >>> kSFracLength;
  assign s_ok     = !s_floor[AW-1] && (s_floor < LINE_END);
  assign kick_go  = (state == IDLE) && bus.tt_kick;
  assign advance  = (state == RUN) && !bus.pe_hold;
  assign last_cap = (cap_cnt == total);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.tt_kick) state_nx = RUN;
      RUN:     if (advance && last_cap) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The last tap shows sample (cap_cnt-1-K); enable while that index is in 0..scan_len-1.
  always_comb begin
    busy_o = (state != IDLE);
    done_o = (state == DONE);
    en_o   = advance && (cap_cnt > CW'(K)) && (cap_cnt <= total);
  end

  // RAM data for an address is registered into data_q one advance later and
  // enters the chain on the advance after that, so every stage freezes on hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc     <= '0;
      step_r  <= '0;
      addr_r  <= '0;
      addr_ok <= 1'b0;
      iss     <= 1'b0;
      adv_q   <= 1'b0;
      data_q  <= '0;
      total   <= '0;
      iss_cnt <= '0;
      cap_cnt <= '0;
      for (int unsigned i = 0; i < CL; i++) chain[i] <= '0;
    end else if (kick_go) begin
      addr_r  <= s_ok ? s_floor[kSLength-1:0] : '0;
      addr_ok <= s_ok;
      acc     <= init_x + step_x;
      step_r  <= step_x;
      total   <= CW'(bus.tt_scan_len) + CW'(K);
      iss_cnt <= CW'(1);
      iss     <= 1'b1;
      adv_q   <= 1'b0;
      cap_cnt <= '0;
    end else if (advance) begin
      if (iss_cnt < total) begin
        addr_r  <= s_ok ? s_floor[kSLength-1:0] : '0;
        addr_ok <= s_ok;
        acc     <= acc + step_r;
        iss_cnt <= iss_cnt + CW'(1);
        iss     <= 1'b1;
      end else begin
        iss     <= 1'b0;
      end
      data_q <= addr_ok ? bus.pv_val : '0;
      adv_q  <= iss;
      if (adv_q) begin
        for (int unsigned i = CL - 1; i > 0; i--) chain[i] <= chain[i-1];
        chain[0] <= data_q;
        cap_cnt  <= cap_cnt + CW'(1);
      end
    end
  end

  // chain[0] is the newest sample, so tap 0 leads by K samples and the last tap trails.
  always_comb begin
    taps = '0;
    for (int unsigned i = 0; i < kNoOfPartitions; i++)
      taps[i*W +: W] = chain[i*kTapDelay];
  end

  assign bus.tt_busy  = busy_o;
  assign bus.tt_done  = done_o;
  assign bus.pe_en    = en_o;
  assign bus.pe_taps  = taps;
  assign bus.pv_s_val = addr_r;
endmodule
